// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory.
// Optional build macro MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt instead of retiring as NOP.
module multi_cycle_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mem_ready,
  input  logic [6:0]           opcode,
  input  logic [2:0]           func3,
  input  logic                 BrEq,
  input  logic                 BrLT,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iorD,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCsel,
  output logic                 regWrite,
  output logic                 ALUSrc_A,
  output logic                 ALUSrc_B,
  output logic [2:0]           ALUOp,
  output logic [1:0]           memtoReg,
  output logic                 busy,
  output logic                 illegal,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [2:0]           state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_legal;
  logic br_taken, retire;
  logic alu_a, alu_b;
  logic [2:0] alu_op;

  always_comb begin
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_I);
    is_ld    = (opcode == OP_LOAD);
    is_st    = (opcode == OP_STORE);
    is_br    = (opcode == OP_BRANCH);
    is_jal   = (opcode == OP_JAL);
    is_jalr  = (opcode == OP_JALR);
    is_legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr;
  end

  always_comb begin
    br_taken = 1'b0;
    case (func3)
      3'b000:  br_taken = BrEq;
      3'b001:  br_taken = !BrEq;
      3'b100:  br_taken = BrLT;
      3'b101:  br_taken = !BrLT;
      default: br_taken = 1'b0;
    endcase
  end

  // ALU setup per class; held from EXEC through WB so ALU_out stays stable.
  always_comb begin
    alu_a  = 1'b0;
    alu_b  = 1'b0;
    alu_op = 3'b000;
    if (is_r) begin
      alu_op = 3'b010;
    end else if (is_i) begin
      alu_b  = 1'b1;
      alu_op = 3'b011;
    end else if (is_ld || is_st || is_jalr) begin
      alu_b  = 1'b1;
    end else if (is_br || is_jal) begin
      alu_a  = 1'b1;
      alu_b  = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCsel    = 1'b0;
    regWrite = 1'b0;
    ALUSrc_A = 1'b0;
    ALUSrc_B = 1'b0;
    ALUOp    = 3'b000;
    memtoReg = 2'b00;
    busy     = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        busy = 1'b1;
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          PCWrite = 1'b1;
          retire  = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        busy     = 1'b1;
        ALUSrc_A = alu_a;
        ALUSrc_B = alu_b;
        ALUOp    = alu_op;
        if (is_br) begin
          PCWrite = 1'b1;
          PCsel   = br_taken;
          retire  = 1'b1;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        busy     = 1'b1;
        ALUSrc_A = alu_a;
        ALUSrc_B = alu_b;
        ALUOp    = alu_op;
        mem_req  = 1'b1;
        iorD     = 1'b1;
        mem_we   = is_st;
        if (mem_ready) begin
          if (is_st) begin
            PCWrite = 1'b1;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        busy     = 1'b1;
        ALUSrc_A = alu_a;
        ALUSrc_B = alu_b;
        ALUOp    = alu_op;
        regWrite = 1'b1;
        PCWrite  = 1'b1;
        PCsel    = is_jal | is_jalr;
        if (is_jal || is_jalr) memtoReg = 2'b10;
        else if (is_r || is_i) memtoReg = 2'b01;
        else                   memtoReg = 2'b00;
        retire   = 1'b1;
      end
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
      S_HALT: begin
        illegal = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // start is only looked at on retire, so a mid-instruction drop is deferred.
    if (retire) state_d = start ? S_FETCH : S_IDLE;
  end

  always_comb begin
    instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, retire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl with hand-computed expectations.
// Honours MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN to pick the illegal-opcode expectations.
module tb_multi_cycle_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mem_ready;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        BrEq;
  logic        BrLT;
  logic        mem_req, mem_we, iorD, IRWrite, PCWrite, PCsel, regWrite;
  logic        ALUSrc_A, ALUSrc_B;
  logic [2:0]  ALUOp;
  logic [1:0]  memtoReg;
  logic        busy, illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  int n_cmp;
  int n_err;

  multi_cycle_ctrl #(.INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready),
    .opcode(opcode), .func3(func3), .BrEq(BrEq), .BrLT(BrLT),
    .mem_req(mem_req), .mem_we(mem_we), .iorD(iorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCsel(PCsel), .regWrite(regWrite),
    .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .ALUOp(ALUOp),
    .memtoReg(memtoReg), .busy(busy), .illegal(illegal),
    .state(state), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
    opcode = 7'b0; func3 = 3'b0; BrEq = 1'b0; BrLT = 1'b0;
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_memreq", 32'(mem_req), 32'd0);
    step();
    rst = 1'b0;
    step();

    // R-type with memory always ready
    start = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011;
    #1;
    check("idle_state", 32'(state), 32'd0);
    step();
    check("r_fetch_state", 32'(state), 32'd1);
    check("r_fetch_memreq", 32'(mem_req), 32'd1);
    check("r_fetch_iord", 32'(iorD), 32'd0);
    check("r_fetch_irw", 32'(IRWrite), 32'd1);
    check("r_fetch_busy", 32'(busy), 32'd1);
    step();
    check("r_dec_state", 32'(state), 32'd2);
    check("r_dec_pcw", 32'(PCWrite), 32'd0);
    step();
    check("r_exec_state", 32'(state), 32'd3);
    check("r_exec_aluop", 32'(ALUOp), 32'b010);
    check("r_exec_pcw", 32'(PCWrite), 32'd0);
    step();
    check("r_wb_state", 32'(state), 32'd5);
    check("r_wb_regw", 32'(regWrite), 32'd1);
    check("r_wb_m2r", 32'(memtoReg), 32'b01);
    check("r_wb_aluop", 32'(ALUOp), 32'b010);
    check("r_wb_pcw", 32'(PCWrite), 32'd1);
    check("r_wb_pcsel", 32'(PCsel), 32'd0);
    step();
    check("r_next_state", 32'(state), 32'd1);
    check("r_instret", instret, 32'd1);

    // LOAD with 3 wait cycles in MEM
    opcode = 7'b0000011;
    step();
    check("ld_dec_state", 32'(state), 32'd2);
    step();
    check("ld_exec_state", 32'(state), 32'd3);
    check("ld_exec_b", 32'(ALUSrc_B), 32'd1);
    check("ld_exec_aluop", 32'(ALUOp), 32'b000);
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      check("ld_mem_state", 32'(state), 32'd4);
      check("ld_mem_req", 32'(mem_req), 32'd1);
      check("ld_mem_iord", 32'(iorD), 32'd1);
      check("ld_mem_we", 32'(mem_we), 32'd0);
      check("ld_mem_pcw", 32'(PCWrite), 32'd0);
      step();
    end
    check("ld_wb_state", 32'(state), 32'd5);
    check("ld_wb_m2r", 32'(memtoReg), 32'b00);
    check("ld_wb_regw", 32'(regWrite), 32'd1);
    check("ld_wb_b", 32'(ALUSrc_B), 32'd1);
    step();
    check("ld_instret", instret, 32'd2);

    // BNE taken, then retire to IDLE
    opcode = 7'b1100011; func3 = 3'b001; BrEq = 1'b0;
    step();
    step();
    check("bne_exec_state", 32'(state), 32'd3);
    check("bne_exec_pcw", 32'(PCWrite), 32'd1);
    check("bne_exec_pcsel", 32'(PCsel), 32'd1);
    check("bne_exec_a", 32'(ALUSrc_A), 32'd1);
    start = 1'b0;
    step();
    check("bne_idle_state", 32'(state), 32'd0);
    check("bne_idle_busy", 32'(busy), 32'd0);
    check("bne_instret", instret, 32'd3);

    // BNE not taken
    start = 1'b1; BrEq = 1'b1;
    step();
    step();
    step();
    check("bnen_exec_state", 32'(state), 32'd3);
    check("bnen_exec_pcw", 32'(PCWrite), 32'd1);
    check("bnen_exec_pcsel", 32'(PCsel), 32'd0);
    // BLT taken vs unused func3 on same cycle
    func3 = 3'b100; BrLT = 1'b1;
    #1;
    check("blt_pcsel", 32'(PCsel), 32'd1);
    func3 = 3'b010;
    #1;
    check("f3_010_pcsel", 32'(PCsel), 32'd0);
    func3 = 3'b101;
    #1;
    check("bge_pcsel", 32'(PCsel), 32'd0);
    start = 1'b0;
    step();
    check("bnen_idle_state", 32'(state), 32'd0);
    check("bnen_instret", instret, 32'd4);

    // JAL
    start = 1'b1; opcode = 7'b1101111;
    step();
    step();
    step();
    check("jal_exec_state", 32'(state), 32'd3);
    check("jal_exec_a", 32'(ALUSrc_A), 32'd1);
    check("jal_exec_b", 32'(ALUSrc_B), 32'd1);
    check("jal_exec_aluop", 32'(ALUOp), 32'b000);
    step();
    check("jal_wb_state", 32'(state), 32'd5);
    check("jal_wb_m2r", 32'(memtoReg), 32'b10);
    check("jal_wb_pcsel", 32'(PCsel), 32'd1);
    check("jal_wb_regw", 32'(regWrite), 32'd1);
    step();
    check("jal_instret", instret, 32'd5);
    check("jal_next_state", 32'(state), 32'd1);

    // STORE aborted by reset mid-MEM
    opcode = 7'b0100011;
    step();
    step();
    mem_ready = 1'b0;
    step();
    check("st_mem_state", 32'(state), 32'd4);
    check("st_mem_we", 32'(mem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("st_rst_state", 32'(state), 32'd0);
    check("st_rst_memreq", 32'(mem_req), 32'd0);
    check("st_rst_memwe", 32'(mem_we), 32'd0);
    check("st_rst_instret", instret, 32'd0);
    check("st_rst_busy", 32'(busy), 32'd0);
    start = 1'b0; mem_ready = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_post_memwe", 32'(mem_we), 32'd0);
      check("st_post_state", 32'(state), 32'd0);
    end

    // Illegal opcode
    start = 1'b1; opcode = 7'b1111111;
    step();
    step();
    check("ill_dec_state", 32'(state), 32'd2);
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
    check("ill_dec_pcw", 32'(PCWrite), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("ill_halt_state", 32'(state), 32'd6);
      check("ill_halt_flag", 32'(illegal), 32'd1);
      check("ill_halt_busy", 32'(busy), 32'd0);
      check("ill_halt_instret", instret, 32'd0);
    end
`else
    check("ill_dec_pcw", 32'(PCWrite), 32'd1);
    check("ill_dec_pcsel", 32'(PCsel), 32'd0);
    check("ill_flag", 32'(illegal), 32'd0);
    step();
    check("ill_next_state", 32'(state), 32'd1);
    check("ill_instret", instret, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
